// File: rtl/punc_controller.sv
// punc_controller: control FSM for the PUnC LC3 processor.
// Steps the datapath through FETCH -> DECODE -> EXEC (-> INDIR) for each
// instruction. Every datapath control is decoded combinationally from the
// current state, the IR and the latched N/Z/P flags.
// Optional feature macro: PUNC_INDIRECT_EN enables LDI/STI through the INDIR
// state and drives mdr_ld. Without it, LDI/STI decode as 3-cycle no-ops.
module punc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic [1:0]  pc_sel,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_w_en,
    output logic        mdr_ld,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic [2:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [1:0]  rf_w_sel,
    output logic [1:0]  alu_op,
    output logic        alu_imm,
    output logic        npz_ld,
    output logic        halted
);

`ifdef PUNC_INDIRECT_EN
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_INDIR, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_HALT
    } state_t;
`endif

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;
`ifdef PUNC_INDIRECT_EN
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
`endif

    localparam logic [1:0] PC_INC   = 2'b00;
    localparam logic [1:0] PC_OFF9  = 2'b01;
    localparam logic [1:0] PC_OFF11 = 2'b10;
    localparam logic [1:0] PC_BASE  = 2'b11;

    localparam logic [1:0] MA_PC    = 2'b00;
    localparam logic [1:0] MA_OFF9  = 2'b01;
    localparam logic [1:0] MA_BASE6 = 2'b10;
    localparam logic [1:0] MA_MDR   = 2'b11;

    localparam logic [1:0] WS_ALU   = 2'b00;
    localparam logic [1:0] WS_MEM   = 2'b01;
    localparam logic [1:0] WS_PC    = 2'b10;
    localparam logic [1:0] WS_LEA   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOT  = 2'b11;

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;
    logic [2:0] dr;
    logic [2:0] base;
    logic       branch_taken;
    logic       unused_bits;

    assign opcode       = instruction[15:12];
    assign dr           = instruction[11:9];
    assign base         = instruction[8:6];
    assign branch_taken = (instruction[11] & n) | (instruction[10] & z) | (instruction[9] & p);
    // instruction[4:3] carry no control information for any opcode.
    assign unused_bits  = ^instruction[4:3];

`ifndef PUNC_INDIRECT_EN
    assign mdr_ld = 1'b0;
`endif

    // State register; rst drops straight back to FETCH, aborting any instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all datapath controls; everything is held low while rst is high.
    always_comb begin
        state_next   = state;
        ir_ld        = 1'b0;
        pc_ld        = 1'b0;
        pc_sel       = PC_INC;
        mem_addr_sel = MA_PC;
        mem_w_en     = 1'b0;
`ifdef PUNC_INDIRECT_EN
        mdr_ld       = 1'b0;
`endif
        rf_r_addr_0  = 3'd0;
        rf_r_addr_1  = 3'd0;
        rf_w_addr    = 3'd0;
        rf_w_en      = 1'b0;
        rf_w_sel     = WS_ALU;
        alu_op       = 2'b00;
        alu_imm      = 1'b0;
        npz_ld       = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_addr_sel = MA_PC;
                    ir_ld        = 1'b1;
                    state_next   = S_DECODE;
                end
                S_DECODE: begin
                    pc_ld      = 1'b1;
                    pc_sel     = PC_INC;
                    state_next = (opcode == OP_TRAP) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    state_next = S_FETCH;
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            rf_r_addr_0 = base;
                            rf_r_addr_1 = instruction[2:0];
                            alu_imm     = instruction[5];
                            alu_op      = (opcode == OP_ADD) ? ALU_ADD :
                                          (opcode == OP_AND) ? ALU_AND : ALU_NOT;
                            rf_w_addr   = dr;
                            rf_w_sel    = WS_ALU;
                            rf_w_en     = 1'b1;
                            npz_ld      = 1'b1;
                        end
                        OP_BR: begin
                            if (branch_taken) begin
                                pc_ld  = 1'b1;
                                pc_sel = PC_OFF9;
                            end
                        end
                        OP_JMP: begin
                            rf_r_addr_0 = base;
                            pc_sel      = PC_BASE;
                            pc_ld       = 1'b1;
                        end
                        OP_JSR: begin
                            // Link and jump share the edge; the base is read before R7 changes.
                            rf_w_addr   = 3'd7;
                            rf_w_sel    = WS_PC;
                            rf_w_en     = 1'b1;
                            rf_r_addr_0 = base;
                            pc_sel      = instruction[11] ? PC_OFF11 : PC_BASE;
                            pc_ld       = 1'b1;
                        end
                        OP_LD, OP_LDR: begin
                            rf_r_addr_0  = base;
                            mem_addr_sel = (opcode == OP_LD) ? MA_OFF9 : MA_BASE6;
                            rf_w_addr    = dr;
                            rf_w_sel     = WS_MEM;
                            rf_w_en      = 1'b1;
                            npz_ld       = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            rf_r_addr_0  = base;
                            rf_r_addr_1  = dr;
                            mem_addr_sel = (opcode == OP_ST) ? MA_OFF9 : MA_BASE6;
                            mem_w_en     = 1'b1;
                        end
                        OP_LEA: begin
                            rf_w_addr = dr;
                            rf_w_sel  = WS_LEA;
                            rf_w_en   = 1'b1;
                        end
`ifdef PUNC_INDIRECT_EN
                        OP_LDI, OP_STI: begin
                            mem_addr_sel = MA_OFF9;
                            mdr_ld       = 1'b1;
                            state_next   = S_INDIR;
                        end
`endif
                        default: begin
                            // RTI, reserved, and LDI/STI when indirection is disabled.
                        end
                    endcase
                end
`ifdef PUNC_INDIRECT_EN
                S_INDIR: begin
                    mem_addr_sel = MA_MDR;
                    state_next   = S_FETCH;
                    if (opcode == OP_LDI) begin
                        rf_w_addr = dr;
                        rf_w_sel  = WS_MEM;
                        rf_w_en   = 1'b1;
                        npz_ld    = 1'b1;
                    end else begin
                        rf_r_addr_1 = dr;
                        mem_w_en    = 1'b1;
                    end
                end
`endif
                S_HALT: begin
                    halted     = 1'b1;
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
